int_wb_port_arbiter: RTL and testbench

//  Downstream of the ALU/MUL-DIV execute group. Merges the ALU1 result stream and the MUL/DIV result stream into one PRF write port.
//  The same merged stream also drives one ROB completion port.
//  ALU has fixed priority. A deferred MUL/DIV result waits in a small FIFO and drains on the first cycle with no ALU result.

---
 rtl/int_wb_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_int_wb_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_wb_port_arbiter.sv
// int_wb_port_arbiter
// Merges the ALU1 and MUL/DIV result streams into one PRF write / ROB
// completion port. ALU has fixed priority. A MUL/DIV result that loses
// arbitration waits in a small in-order FIFO. The FIFO drains on the first
// cycle that has no ALU result.
// Optional feature macro: WB_ARB_PERF_CNT_EN (defer counter and peak
// occupancy). When it is undefined, both perf ports are tied to 0.
//
// Stream protocol: both result inputs are valid-only. A result is consumed in
// every cycle its valid is high, and there is no ready. The ALU path is never
// back-pressured. The MUL/DIV producer must stop issuing while
// muldiv_hold_o is high. One result already in flight still fits in the FIFO.
module int_wb_port_arbiter #(
    parameter int XLEN   = 32,
    parameter int PRF_AW = 6,
    parameter int ROB_TW = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     alu_valid_i,
    input  logic [PRF_AW-1:0]        alu_addr_i,
    input  logic [XLEN-1:0]          alu_data_i,
    input  logic [ROB_TW-1:0]        alu_tag_i,
    input  logic                     md_valid_i,
    input  logic [PRF_AW-1:0]        md_addr_i,
    input  logic [XLEN-1:0]          md_data_i,
    input  logic [ROB_TW-1:0]        md_tag_i,
    output logic                     wb_valid_o,
    output logic [PRF_AW-1:0]        wb_addr_o,
    output logic [XLEN-1:0]          wb_data_o,
    output logic [ROB_TW-1:0]        wb_tag_o,
    output logic                     wb_src_o,
    output logic                     muldiv_hold_o,
    output logic                     overflow_o,
    output logic [31:0]              perf_defer_o,
    output logic [$clog2(DEPTH):0]   perf_maxocc_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = PRF_AW + XLEN + ROB_TW;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [PW-1:0] fifo_count;
    logic          fifo_empty, fifo_full;
    logic          active, do_deq, md_defer, do_enq, md_drop;
    logic [EW-1:0] head;

    // Occupancy flags come from the extra pointer MSB (wrap modulo 2*DEPTH).
    always_comb begin
        fifo_count = wr_ptr - rd_ptr;
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    end

    assign muldiv_hold_o = (fifo_count >= PW'(DEPTH - 1));
    assign head          = mem[rd_ptr[AW-1:0]];

    // Arbitration: ALU wins. The FIFO head comes next, then a direct MUL/DIV
    // result. A MUL/DIV result must be deferred when it loses. It is dropped
    // only when the FIFO is full and nothing drains in the same cycle.
    always_comb begin
        active   = !stall_i && !flush_i;
        do_deq   = active && !alu_valid_i && !fifo_empty;
        md_defer = active && md_valid_i && (alu_valid_i || !fifo_empty);
        do_enq   = md_defer && (!fifo_full || do_deq);
        md_drop  = md_defer && !do_enq;
    end

    // Next pointer values. Flush empties the FIFO. Stall leaves it untouched.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush_i) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (do_enq) wr_ptr_nxt = wr_ptr + 1'b1;
            if (do_deq) rd_ptr_nxt = rd_ptr + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // FIFO storage. Contents are only meaningful between the two pointers.
    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr[AW-1:0]] <= {md_addr_i, md_data_i, md_tag_i};
    end

    // Registered write-back port. Address, data and tag hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_o <= 1'b0;
            wb_addr_o  <= '0;
            wb_data_o  <= '0;
            wb_tag_o   <= '0;
            wb_src_o   <= 1'b0;
        end else if (flush_i) begin
            wb_valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (alu_valid_i) begin
                wb_valid_o <= 1'b1;
                wb_addr_o  <= alu_addr_i;
                wb_data_o  <= alu_data_i;
                wb_tag_o   <= alu_tag_i;
                wb_src_o   <= 1'b0;
            end else if (!fifo_empty) begin
                wb_valid_o <= 1'b1;
                {wb_addr_o, wb_data_o, wb_tag_o} <= head;
                wb_src_o   <= 1'b1;
            end else if (md_valid_i) begin
                wb_valid_o <= 1'b1;
                wb_addr_o  <= md_addr_i;
                wb_data_o  <= md_data_i;
                wb_tag_o   <= md_tag_i;
                wb_src_o   <= 1'b1;
            end else begin
                wb_valid_o <= 1'b0;
            end
        end
    end

    // Sticky overflow flag. Only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_o <= 1'b0;
        else if (md_drop) overflow_o <= 1'b1;
    end

    // A dropped MUL/DIV result means the upstream producer ignored muldiv_hold_o.
    a_no_md_drop: assert property (@(posedge clk) disable iff (!rst_n) !md_drop)
        else $warning("protocol violation: MUL/DIV result dropped while defer FIFO full");

`ifdef WB_ARB_PERF_CNT_EN
    logic [31:0]   defer_cnt;
    logic [AW:0]   maxocc;
    logic [PW-1:0] count_nxt;

    assign count_nxt = wr_ptr_nxt - rd_ptr_nxt;

    // Saturating defer counter and peak occupancy. Flush does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            defer_cnt <= '0;
            maxocc    <= '0;
        end else begin
            if (do_enq && (defer_cnt != 32'hFFFF_FFFF)) defer_cnt <= defer_cnt + 32'd1;
            if (count_nxt > maxocc) maxocc <= count_nxt;
        end
    end

    assign perf_defer_o  = defer_cnt;
    assign perf_maxocc_o = maxocc;
`else
    assign perf_defer_o  = '0;
    assign perf_maxocc_o = '0;
`endif

endmodule

// File: tb/tb_int_wb_port_arbiter.sv
// Testbench for int_wb_port_arbiter: directed vectors, a queue-based reference
// model of the arbitration rules, a per-cycle compare process and literal checks.
module tb_int_wb_port_arbiter;

    localparam int XLEN   = 32;
    localparam int PRF_AW = 6;
    localparam int ROB_TW = 5;
    localparam int DEPTH  = 4;
    localparam int EW     = PRF_AW + XLEN + ROB_TW;

    logic              clk, rst_n, stall_i, flush_i;
    logic              alu_valid_i, md_valid_i;
    logic [PRF_AW-1:0] alu_addr_i, md_addr_i;
    logic [XLEN-1:0]   alu_data_i, md_data_i;
    logic [ROB_TW-1:0] alu_tag_i, md_tag_i;
    logic              wb_valid_o, wb_src_o, muldiv_hold_o, overflow_o;
    logic [PRF_AW-1:0] wb_addr_o;
    logic [XLEN-1:0]   wb_data_o;
    logic [ROB_TW-1:0] wb_tag_o;
    logic [31:0]       perf_defer_o;
    logic [2:0]        perf_maxocc_o;

    int_wb_port_arbiter #(.XLEN(XLEN), .PRF_AW(PRF_AW), .ROB_TW(ROB_TW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .alu_valid_i(alu_valid_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i), .alu_tag_i(alu_tag_i),
        .md_valid_i(md_valid_i), .md_addr_i(md_addr_i), .md_data_i(md_data_i), .md_tag_i(md_tag_i),
        .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_tag_o(wb_tag_o),
        .wb_src_o(wb_src_o), .muldiv_hold_o(muldiv_hold_o), .overflow_o(overflow_o),
        .perf_defer_o(perf_defer_o), .perf_maxocc_o(perf_maxocc_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [EW-1:0]     exp_q[$];
    logic              exp_valid, exp_src, exp_ovf;
    logic [PRF_AW-1:0] exp_addr;
    logic [XLEN-1:0]   exp_data;
    logic [ROB_TW-1:0] exp_tag;
    logic [31:0]       exp_defer;
    int                exp_maxocc;
    int                n_checks = 0;
    int                n_errors = 0;
    logic              run = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_valid = 0; exp_src = 0; exp_ovf = 0;
        exp_addr = '0; exp_data = '0; exp_tag = '0;
        exp_defer = '0; exp_maxocc = 0;
    endtask

    task automatic model_push(input logic [EW-1:0] e);
        exp_q.push_back(e);
        if (exp_defer != 32'hFFFF_FFFF) exp_defer = exp_defer + 1;
    endtask

    // One clock of the arbitration rules, applied to the inputs present at the edge.
    task automatic model_step();
        logic [EW-1:0] e;
        if (flush_i) begin
            exp_q.delete();
            exp_valid = 0;
        end else if (!stall_i) begin
            if (alu_valid_i) begin
                exp_valid = 1; exp_src = 0;
                exp_addr = alu_addr_i; exp_data = alu_data_i; exp_tag = alu_tag_i;
                if (md_valid_i) begin
                    if (exp_q.size() < DEPTH) model_push({md_addr_i, md_data_i, md_tag_i});
                    else exp_ovf = 1;
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                {exp_addr, exp_data, exp_tag} = e;
                exp_valid = 1; exp_src = 1;
                if (md_valid_i) model_push({md_addr_i, md_data_i, md_tag_i});
            end else if (md_valid_i) begin
                exp_valid = 1; exp_src = 1;
                exp_addr = md_addr_i; exp_data = md_data_i; exp_tag = md_tag_i;
            end else begin
                exp_valid = 0;
            end
        end
        if (exp_q.size() > exp_maxocc) exp_maxocc = exp_q.size();
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (run) begin
            check("wb_valid", wb_valid_o, exp_valid);
            check("wb_addr", wb_addr_o, exp_addr);
            check("wb_data", wb_data_o, exp_data);
            check("wb_tag", wb_tag_o, exp_tag);
            check("wb_src", wb_src_o, exp_src);
            check("count", dut.fifo_count, exp_q.size());
            check("hold", muldiv_hold_o, exp_q.size() >= DEPTH - 1);
            check("overflow", overflow_o, exp_ovf);
`ifdef WB_ARB_PERF_CNT_EN
            check("perf_defer", perf_defer_o, exp_defer);
            check("perf_maxocc", perf_maxocc_o, exp_maxocc);
`else
            check("perf_defer", perf_defer_o, 32'd0);
            check("perf_maxocc", perf_maxocc_o, 32'd0);
`endif
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic st, input logic fl,
                       input logic av, input logic [4:0] at,
                       input logic mv, input logic [4:0] mt, input logic [31:0] mdd);
        stall_i = st; flush_i = fl;
        alu_valid_i = av; alu_tag_i = at; alu_addr_i = {1'b1, at}; alu_data_i = 32'hA000_0000 | 32'(at);
        md_valid_i = mv; md_tag_i = mt; md_addr_i = {1'b0, mt}; md_data_i = mdd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        stall_i = 0; flush_i = 0; alu_valid_i = 0; md_valid_i = 0;
        alu_addr_i = '0; alu_data_i = '0; alu_tag_i = '0;
        md_addr_i = '0; md_data_i = '0; md_tag_i = '0;
        model_reset();
        run = 1'b1;
        do_reset();
        check("rst_valid", wb_valid_o, 0);
        check("rst_tag", wb_tag_o, 0);
        check("rst_ovf", overflow_o, 0);

        // 1: ALU only
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 0, 1, 5'(k), 0, 5'd0, 32'd0);
            check("s1_tag", wb_tag_o, k);
            check("s1_src", wb_src_o, 0);
            check("s1_count", dut.fifo_count, 0);
        end
        idle();
        check("s1_idle", wb_valid_o, 0);

        // 2: collision
        cyc(0, 0, 1, 5'd4, 1, 5'd9, 32'hDEAD);
        check("s2_tag_alu", wb_tag_o, 4);
        check("s2_count1", dut.fifo_count, 1);
        idle();
        check("s2_tag_md", wb_tag_o, 9);
        check("s2_data_md", wb_data_o, 32'hDEAD);
        check("s2_src_md", wb_src_o, 1);
        check("s2_count0", dut.fifo_count, 0);

        // 6: async reset in the middle of a drain
        cyc(0, 0, 1, 5'd5, 1, 5'd13, 32'h1013);
        cyc(0, 0, 1, 5'd6, 1, 5'd14, 32'h1014);
        idle();
        check("s6_drain_tag", wb_tag_o, 13);
        check("s6_drain_count", dut.fifo_count, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("s6_async_valid", wb_valid_o, 0);
        check("s6_async_count", dut.fifo_count, 0);
`ifdef WB_ARB_PERF_CNT_EN
        check("s6_perf_defer", perf_defer_o, 0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 3: fill to 3 then drain in order
        for (int k = 0; k < 3; k++)
            cyc(0, 0, 1, 5'(k + 1), 1, 5'(k + 10), 32'h1000 + 32'(k + 10));
        check("s3_count3", dut.fifo_count, 3);
        check("s3_hold1", muldiv_hold_o, 1);
        for (int k = 0; k < 3; k++) begin
            idle();
            check("s3_tag", wb_tag_o, k + 10);
            check("s3_src", wb_src_o, 1);
        end
        idle();
        check("s3_done", wb_valid_o, 0);
`ifdef WB_ARB_PERF_CNT_EN
        check("s3_perf_defer", perf_defer_o, 3);
        check("s3_perf_maxocc", perf_maxocc_o, 3);
`endif

        // 4: overflow
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 1, 5'(k + 1), 1, 5'(k + 16), 32'h2000 + 32'(k));
        check("s4_count4", dut.fifo_count, 4);
        cyc(0, 0, 1, 5'd7, 1, 5'd20, 32'h2020);
        check("s4_ovf", overflow_o, 1);
        check("s4_count_still4", dut.fifo_count, 4);
        for (int k = 0; k < 4; k++) begin
            idle();
            check("s4_tag", wb_tag_o, k + 16);
        end
        idle();
        check("s4_done", wb_valid_o, 0);

        // 5: stall then flush
        cyc(0, 0, 1, 5'd8, 1, 5'd21, 32'h3021);
        cyc(0, 0, 1, 5'd9, 1, 5'd22, 32'h3022);
        check("s5_count2", dut.fifo_count, 2);
        for (int k = 0; k < 2; k++) begin
            cyc(1, 0, 1, 5'd10, 1, 5'd23, 32'h3023);
            check("s5_stall_valid", wb_valid_o, 1);
            check("s5_stall_tag", wb_tag_o, 9);
            check("s5_stall_count", dut.fifo_count, 2);
        end
        cyc(1, 1, 1, 5'd11, 1, 5'd24, 32'h3024);
        check("s5_flush_valid", wb_valid_o, 0);
        check("s5_flush_count", dut.fifo_count, 0);
        check("s5_flush_hold", muldiv_hold_o, 0);
        check("s5_flush_ovf", overflow_o, 1);
        idle();
        check("s5_after_flush", wb_valid_o, 0);
        idle();

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
